// File: rtl/pe_seq_pkg.sv
// Shared definitions for the PE dataflow sequencer: state encoding and default group sizes.
package pe_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_W = 3'd1,
    ST_LOAD_I = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_OUT    = 3'd4,
    ST_FINISH = 3'd5
  } seq_state_e;

  localparam int DEF_W_GROUP     = 4;
  localparam int DEF_O_GROUP     = 4;
  localparam int DEF_I_GROUP     = DEF_W_GROUP + DEF_O_GROUP - 1;
  localparam int DEF_BLOCK_COUNT = 4;
  localparam int DEF_CNT_W       = 3;
  localparam int DEF_PIPE_LAT    = 2;

endpackage

// File: rtl/seq_beat_counter.sv
// Clearable up-counter with terminal-value compare; never wraps on its own.
module seq_beat_counter #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             aclr_n,
  input  logic             clr_i,
  input  logic             inc_i,
  input  logic [CNT_W-1:0] term_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             at_term_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o     = cnt_q;
  assign at_term_o = (cnt_q == term_i);

endmodule

// File: rtl/pe_dataflow_sequencer.sv
// Tile sequencer: weight load, BLOCK_COUNT x (input stream, drain, unload), done pulse.
// Define PE_SEQ_WEIGHT_RELOAD_EN to reload weights before every block.
module pe_dataflow_sequencer
  import pe_seq_pkg::*;
#(
  parameter int W_GROUP     = DEF_W_GROUP,
  parameter int O_GROUP     = DEF_O_GROUP,
  parameter int I_GROUP     = DEF_I_GROUP,
  parameter int BLOCK_COUNT = DEF_BLOCK_COUNT,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int PIPE_LAT    = DEF_PIPE_LAT
) (
  input  logic             clk,
  input  logic             aclr_n,
  input  logic             sclr,
  input  logic             start,
  output logic             busy,
  output logic             done,
  input  logic             w_valid,
  output logic             w_ready,
  input  logic             i_valid,
  output logic             i_ready,
  output logic             o_valid,
  input  logic             o_ready,
  output logic             en_w,
  output logic             en_i,
  output logic             en_o_in,
  output logic             en_o_out,
  output logic [CNT_W-1:0] block_idx
);

  localparam logic [CNT_W-1:0] W_TERM = CNT_W'(W_GROUP - 1);
  localparam logic [CNT_W-1:0] I_TERM = CNT_W'(I_GROUP - 1);
  localparam logic [CNT_W-1:0] O_TERM = CNT_W'(O_GROUP - 1);
  localparam logic [CNT_W-1:0] D_TERM = CNT_W'(PIPE_LAT - 1);
  localparam logic [CNT_W-1:0] B_TERM = CNT_W'(BLOCK_COUNT - 1);
  localparam logic [CNT_W-1:0] O_LIM  = CNT_W'(O_GROUP);

`ifdef PE_SEQ_WEIGHT_RELOAD_EN
  localparam seq_state_e NEXT_BLOCK_ST = ST_LOAD_W;
`else
  localparam seq_state_e NEXT_BLOCK_ST = ST_LOAD_I;
`endif

  seq_state_e       state_q, state_d;

  logic [CNT_W-1:0] beat_cnt, beat_term;
  logic             beat_at_term, beat_inc, beat_clr, beat_last;
  logic             blk_at_term, blk_inc, blk_clr;

  // The beat counter doubles as the drain timer: DRAIN never overlaps a handshake state.
  always_comb begin
    beat_term = W_TERM;
    case (state_q)
      ST_LOAD_I: beat_term = I_TERM;
      ST_DRAIN:  beat_term = D_TERM;
      ST_OUT:    beat_term = O_TERM;
      default:   beat_term = W_TERM;
    endcase
  end

  assign beat_inc  = en_w | en_i | en_o_out | (state_q == ST_DRAIN);
  assign beat_last = beat_inc & beat_at_term;
  assign beat_clr  = sclr | beat_last | (state_q == ST_IDLE);

  assign blk_inc = (state_q == ST_OUT) & beat_last & ~blk_at_term;
  assign blk_clr = sclr | (state_q == ST_IDLE) | (state_q == ST_FINISH);

  seq_beat_counter #(.CNT_W(CNT_W)) u_beat_cnt (
    .clk       (clk),
    .aclr_n    (aclr_n),
    .clr_i     (beat_clr),
    .inc_i     (beat_inc),
    .term_i    (beat_term),
    .cnt_o     (beat_cnt),
    .at_term_o (beat_at_term)
  );

  seq_beat_counter #(.CNT_W(CNT_W)) u_block_cnt (
    .clk       (clk),
    .aclr_n    (aclr_n),
    .clr_i     (blk_clr),
    .inc_i     (blk_inc),
    .term_i    (B_TERM),
    .cnt_o     (block_idx),
    .at_term_o (blk_at_term)
  );

  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (sclr) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:   if (start)     state_d = ST_LOAD_W;
        ST_LOAD_W: if (beat_last) state_d = ST_LOAD_I;
        ST_LOAD_I: if (beat_last) state_d = ST_DRAIN;
        ST_DRAIN:  if (beat_last) state_d = ST_OUT;
        ST_OUT:    if (beat_last) state_d = blk_at_term ? ST_FINISH : NEXT_BLOCK_ST;
        ST_FINISH: state_d = ST_IDLE;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  // Enables follow the partner handshake combinationally so they fire in the accepting cycle.
  always_comb begin
    busy     = 1'b0;
    done     = 1'b0;
    w_ready  = 1'b0;
    i_ready  = 1'b0;
    o_valid  = 1'b0;
    en_w     = 1'b0;
    en_i     = 1'b0;
    en_o_in  = 1'b0;
    en_o_out = 1'b0;
    case (state_q)
      ST_LOAD_W: begin
        busy    = 1'b1;
        w_ready = 1'b1;
        en_w    = w_valid;
      end
      ST_LOAD_I: begin
        busy    = 1'b1;
        i_ready = 1'b1;
        en_i    = i_valid;
        en_o_in = i_valid & (beat_cnt < O_LIM);
      end
      ST_DRAIN: begin
        busy = 1'b1;
      end
      ST_OUT: begin
        busy     = 1'b1;
        o_valid  = 1'b1;
        en_o_out = o_ready;
      end
      ST_FINISH: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_pe_dataflow_sequencer.sv
// Directed bench for pe_dataflow_sequencer; expectations follow PE_SEQ_WEIGHT_RELOAD_EN when defined.
module tb_pe_dataflow_sequencer;

  localparam int CNT_W = 3;
  localparam int O_GRP = 4;
`ifdef PE_SEQ_WEIGHT_RELOAD_EN
  localparam int EXP_W    = 16;
  localparam int EXP_BUSY = 69;
`else
  localparam int EXP_W    = 4;
  localparam int EXP_BUSY = 57;
`endif

  logic clk = 1'b0;
  logic aclr_n, sclr, start, w_valid, i_valid, o_ready;
  logic busy, done, w_ready, i_ready, o_valid, en_w, en_i, en_o_in, en_o_out;
  logic [CNT_W-1:0] block_idx;

  pe_dataflow_sequencer #(
    .W_GROUP(4), .O_GROUP(4), .I_GROUP(7), .BLOCK_COUNT(4), .CNT_W(CNT_W), .PIPE_LAT(2)
  ) dut (
    .clk(clk), .aclr_n(aclr_n), .sclr(sclr), .start(start), .busy(busy), .done(done),
    .w_valid(w_valid), .w_ready(w_ready), .i_valid(i_valid), .i_ready(i_ready),
    .o_valid(o_valid), .o_ready(o_ready), .en_w(en_w), .en_i(en_i),
    .en_o_in(en_o_in), .en_o_out(en_o_out), .block_idx(block_idx)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;
  int n_w, n_i, n_oin, n_oout, n_busy, n_done, blk_err, base_blk;

  typedef struct {
    logic        st, wv, iv, ordy;
    logic [11:0] exp;
  } vec_t;
  vec_t vecs[25];

  function automatic vec_t mk(input logic st, wv, iv, ordy, bz, dn, wr, ew, ir, ei, eoi, ov, eoo,
                              input logic [2:0] blk);
    vec_t v;
    v.st = st; v.wv = wv; v.iv = iv; v.ordy = ordy;
    v.exp = {bz, dn, wr, ew, ir, ei, eoi, ov, eoo, blk};
    return v;
  endfunction

  function automatic logic [11:0] outs();
    return {busy, done, w_ready, en_w, i_ready, en_i, en_o_in, o_valid, en_o_out, block_idx};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end else begin
      $display("[TB] ok %s = %0h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_counts();
    n_w = 0; n_i = 0; n_oin = 0; n_oout = 0; n_busy = 0; n_done = 0; blk_err = 0; base_blk = 0;
  endtask

  task automatic count_cycle();
    if (en_w) n_w++;
    if (en_i) n_i++;
    if (en_o_in) n_oin++;
    if (en_o_out) begin
      if (int'(block_idx) != base_blk + n_oout / O_GRP) blk_err++;
      n_oout++;
    end
    if (busy) n_busy++;
    if (done) n_done++;
  endtask

  task automatic do_reset();
    aclr_n = 1'b0; sclr = 1'b0; start = 1'b0;
    w_valid = 1'b0; i_valid = 1'b0; o_ready = 1'b0;
    #1;
    @(posedge clk);
    #1;
    aclr_n = 1'b1;
  endtask

  task automatic run_tile(input int budget, output bit seen);
    clear_counts();
    seen = 1'b0;
    start = 1'b1; w_valid = 1'b1; i_valid = 1'b1; o_ready = 1'b1;
    for (int k = 0; k < budget && !seen; k++) begin
      #1;
      count_cycle();
      if (done) seen = 1'b1;
      tick();
      start = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen, found;
    int e0, e1, e2;

    //             st wv iv or | bz dn wr ew ir ei eoi ov eoo blk
    vecs[0]  = mk(0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0,  0, 0,  3'd0);
    vecs[1]  = mk(1, 1, 1, 1,   0, 0, 0, 0, 0, 0, 0,  0, 0,  3'd0);
    vecs[2]  = mk(0, 1, 0, 0,   1, 0, 1, 1, 0, 0, 0,  0, 0,  3'd0);
    vecs[3]  = mk(0, 0, 1, 1,   1, 0, 1, 0, 0, 0, 0,  0, 0,  3'd0);
    vecs[4]  = mk(0, 1, 0, 0,   1, 0, 1, 1, 0, 0, 0,  0, 0,  3'd0);
    vecs[5]  = mk(0, 0, 0, 0,   1, 0, 1, 0, 0, 0, 0,  0, 0,  3'd0);
    vecs[6]  = mk(1, 1, 0, 0,   1, 0, 1, 1, 0, 0, 0,  0, 0,  3'd0);
    vecs[7]  = mk(0, 0, 0, 0,   1, 0, 1, 0, 0, 0, 0,  0, 0,  3'd0);
    vecs[8]  = mk(0, 1, 0, 0,   1, 0, 1, 1, 0, 0, 0,  0, 0,  3'd0);
    vecs[9]  = mk(0, 0, 1, 0,   1, 0, 0, 0, 1, 1, 1,  0, 0,  3'd0);
    vecs[10] = mk(0, 0, 0, 0,   1, 0, 0, 0, 1, 0, 0,  0, 0,  3'd0);
    vecs[11] = mk(0, 0, 1, 0,   1, 0, 0, 0, 1, 1, 1,  0, 0,  3'd0);
    vecs[12] = mk(0, 0, 1, 0,   1, 0, 0, 0, 1, 1, 1,  0, 0,  3'd0);
    vecs[13] = mk(0, 0, 1, 0,   1, 0, 0, 0, 1, 1, 1,  0, 0,  3'd0);
    vecs[14] = mk(0, 0, 1, 0,   1, 0, 0, 0, 1, 1, 0,  0, 0,  3'd0);
    vecs[15] = mk(0, 0, 1, 0,   1, 0, 0, 0, 1, 1, 0,  0, 0,  3'd0);
    vecs[16] = mk(0, 0, 1, 0,   1, 0, 0, 0, 1, 1, 0,  0, 0,  3'd0);
    vecs[17] = mk(0, 1, 1, 1,   1, 0, 0, 0, 0, 0, 0,  0, 0,  3'd0);
    vecs[18] = mk(0, 1, 1, 1,   1, 0, 0, 0, 0, 0, 0,  0, 0,  3'd0);
    vecs[19] = mk(0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0,  1, 0,  3'd0);
    vecs[20] = mk(0, 0, 0, 1,   1, 0, 0, 0, 0, 0, 0,  1, 1,  3'd0);
    vecs[21] = mk(0, 0, 0, 1,   1, 0, 0, 0, 0, 0, 0,  1, 1,  3'd0);
    vecs[22] = mk(0, 0, 0, 1,   1, 0, 0, 0, 0, 0, 0,  1, 1,  3'd0);
    vecs[23] = mk(0, 0, 0, 1,   1, 0, 0, 0, 0, 0, 0,  1, 1,  3'd0);
`ifdef PE_SEQ_WEIGHT_RELOAD_EN
    vecs[24] = mk(0, 0, 0, 0,   1, 0, 1, 0, 0, 0, 0,  0, 0,  3'd1);
`else
    vecs[24] = mk(0, 0, 0, 0,   1, 0, 0, 0, 1, 0, 0,  0, 0,  3'd1);
`endif

    aclr_n = 1'b1; sclr = 1'b0; start = 1'b0;
    w_valid = 1'b0; i_valid = 1'b0; o_ready = 1'b0;
    #1 aclr_n = 1'b0;
    #2;
    check("reset_outputs", 32'(outs()), 32'd0);

    // Table: start, toggling w_valid, i_valid gap, drain, o_ready gap, first block boundary
    do_reset();
    for (int i = 0; i < 25; i++) begin
      start = vecs[i].st; w_valid = vecs[i].wv; i_valid = vecs[i].iv; o_ready = vecs[i].ordy;
      #1;
      check($sformatf("vec%0d", i), 32'(outs()), 32'(vecs[i].exp));
      tick();
    end

    // Nominal tile, with start pulses during busy and in the FINISH cycle
    do_reset();
    clear_counts();
    w_valid = 1'b1; i_valid = 1'b1; o_ready = 1'b1; start = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin
      #1;
      count_cycle();
      if (done) begin
        seen = 1'b1;
        start = 1'b1;
      end
      tick();
      start = (k == 9);
    end
    check("nom_done_seen", 32'(seen), 32'd1);
    #1;
    check("finish_start_ignored", 32'(busy), 32'd0);
    e0 = 0;
    for (int k = 0; k < 3; k++) begin
      tick(); #1;
      if (busy) e0++;
    end
    check("idle_stays_idle", 32'(e0), 32'd0);
    check("nom_en_w", 32'(n_w), 32'(EXP_W));
    check("nom_en_i", 32'(n_i), 32'd28);
    check("nom_en_o_in", 32'(n_oin), 32'd16);
    check("nom_en_o_out", 32'(n_oout), 32'd16);
    check("nom_done_cnt", 32'(n_done), 32'd1);
    check("nom_busy_cycles", 32'(n_busy), 32'(EXP_BUSY));
    check("nom_block_idx", 32'(blk_err), 32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    #1;
    check("idle_start_accepted", 32'(busy), 32'd1);

    // o_ready held low for 10 cycles in block 1 OUT
    do_reset();
    w_valid = 1'b1; i_valid = 1'b1; o_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 200; k++) begin
      #1;
      if (o_valid && block_idx == 3'd1) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    check("stall_reach_blk1_out", 32'(found), 32'd1);
    o_ready = 1'b0;
    e0 = 0; e1 = 0; e2 = 0;
    for (int k = 0; k < 10; k++) begin
      #1;
      if (o_valid) e0++;
      if (block_idx == 3'd1) e1++;
      if (en_o_out) e2++;
      tick();
    end
    check("stall_o_valid", 32'(e0), 32'd10);
    check("stall_block_idx", 32'(e1), 32'd10);
    check("stall_en_o_out", 32'(e2), 32'd0);
    o_ready = 1'b1;
    clear_counts();
    base_blk = 1;
    seen = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin
      #1;
      count_cycle();
      if (done) seen = 1'b1;
      tick();
    end
    check("stall_done_seen", 32'(seen), 32'd1);
    check("stall_en_o_out_rest", 32'(n_oout), 32'd12);
    check("stall_block_idx_rest", 32'(blk_err), 32'd0);

    // Asynchronous reset in the middle of block 2 LOAD_I
    do_reset();
    clear_counts();
    w_valid = 1'b1; i_valid = 1'b1; o_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 200; k++) begin
      #1;
      count_cycle();
      if (i_ready && block_idx == 3'd2) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    check("areset_reach_blk2", 32'(found), 32'd1);
    tick(); tick();
    #1;
    aclr_n = 1'b0;
    #1;
    check("areset_async_outputs", 32'(outs()), 32'd0);
    @(posedge clk);
    #1;
    check("areset_hold_outputs", 32'(outs()), 32'd0);
    aclr_n = 1'b1;
    e0 = 0;
    for (int k = 0; k < 3; k++) begin
      tick(); #1;
      if (busy || done) e0++;
    end
    check("areset_idle_no_done", 32'(e0 + n_done), 32'd0);
    run_tile(200, seen);
    check("areset_retile_done", 32'(seen), 32'd1);
    check("areset_retile_en_i", 32'(n_i), 32'd28);
    check("areset_retile_en_o_out", 32'(n_oout), 32'd16);
    check("areset_retile_block_idx", 32'(blk_err), 32'd0);

    // Synchronous clear during block 0 OUT
    do_reset();
    w_valid = 1'b1; i_valid = 1'b1; o_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 200; k++) begin
      #1;
      if (o_valid) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    check("sclr_reach_out", 32'(found), 32'd1);
    sclr = 1'b1;
    tick();
    sclr = 1'b0;
    #1;
    check("sclr_outputs", 32'(outs()), 32'd0);
    tick();
    run_tile(200, seen);
    check("sclr_retile_done", 32'(seen), 32'd1);
    check("sclr_retile_en_w", 32'(n_w), 32'(EXP_W));
    check("sclr_retile_en_o_in", 32'(n_oin), 32'd16);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
